id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter RF_BYPASS, default 1, meaning: 1 = register-file read returns same-cycle write-back data; 0 = returns old contents.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 inst_id  input  32  instruction from fetch stage, valid every cycle.
REQ-005 pc_id  input  30 [31:2]  word PC of inst_id.
REQ-006 stall  input  1  global pipeline hold.
REQ-007 rst_pipe  input  1  pipeline flush request.
REQ-008 jmp_flush  input  1  taken jump, branch, trap or return in EX; kills the instruction in ID.
REQ-009 wb_wen  input  1; wb_rd  input  5; wb_data  input  32: register write-back port.
REQ-010 stall_ld  output  1  load-use hazard, combinational; fetch holds its PC when high.
REQ-011 pc_ex  output  30 [31:2]; opcode_ex  output  7; funct3_ex  output  3; funct7b5_ex  output  1.
REQ-012 rs1_ex, rs2_ex, rd_ex  output  5 each; rd_wen_ex  output  1; cmd_ld_ex  output  1; illegal_ex  output  1.
REQ-013 rs1_data_ex, rs2_data_ex, imm_ex  output  32 each.

Function
REQ-014 Register file: 31 x 32-bit entries x1..x31, two combinational reads (inst_id[19:15], inst_id[24:20]) and one write on clk when wb_wen=1 and wb_rd!=0.
REQ-015 x0 reads 0; writes to x0 are ignored.
REQ-016 RF_BYPASS=1: read index == wb_rd, wb_wen=1, wb_rd!=0 -> read returns wb_data in the same cycle.
REQ-017 Immediate, sign-extended from inst[31]: I-type (0000011, 0010011, 1100111, 1110011), S (0100011), B (1100011, bit0=0), U (0110111, 0010111, low 12 bits=0), J (1101111, bit0=0); all other opcodes -> 0.
REQ-018 rd_wen: 1 for opcodes 0110111, 0010111, 1101111, 1100111, 0000011, 0010011, 0110011, and 1110011 with funct3!=0; forced 0 when rd==0 or the instruction is illegal.
REQ-019 Illegal: inst[1:0]!=2'b11, or opcode outside {0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, 1110011}.
REQ-020 rs1 used by all opcodes except U, J and 0001111; rs2 used only by 1100011, 0100011 and 0110011.
REQ-021 stall_ld = cmd_ld_ex & (rd_ex!=0) & ((rs1 used & rs1==rd_ex) | (rs2 used & rs2==rd_ex)); never asserted while rst=1.
REQ-022 ID->EX register update priority, one cycle latency: rst, then rst_pipe or jmp_flush, then stall, then stall_ld, then normal.
REQ-023 rst, rst_pipe or jmp_flush -> bubble: opcode_ex=0010011, all other EX fields 0, pc_ex=0.
REQ-024 stall -> all EX fields hold their values.
REQ-025 stall_ld without stall -> bubble loaded (pc_ex=pc_id); the held instruction re-decodes next cycle with cmd_ld_ex=0, so stall_ld lasts exactly one cycle per hazard.
REQ-026 Normal -> all EX fields load the decode of inst_id/pc_id; rs1/rs2 data are sampled including the REQ-016 bypass.
REQ-027 Write-back is independent of stall and flush; writes always occur.

Reset
REQ-028 While rst=1 at a clock edge, every EX output becomes the bubble of REQ-023 and stall_ld=0.
REQ-029 Register-file contents are not reset; x0 still reads 0.
REQ-030 rst asserted mid-hazard or mid-stall wins over every other condition in the next cycle.

Verification
REQ-031 Write x5=0x1234_5678, then decode add x6,x5,x0 -> next cycle: rs1_data_ex=0x12345678, rd_ex=6, rd_wen_ex=1.
REQ-032 lw x7,0(x1) followed by addi x8,x7,1 -> stall_ld=1 for one cycle, bubble in EX, then addi in EX with rs1_ex=7.
REQ-033 Same-cycle wb_wen=1, wb_rd=9, wb_data=0xA5A5_A5A5 while decoding x9 as rs2 -> rs2_data_ex=0xA5A5A5A5 (RF_BYPASS=1); old value when RF_BYPASS=0.
REQ-034 jmp_flush=1 together with stall=1 and a pending load-use hazard -> EX becomes the bubble (opcode 0010011, rd_wen_ex=0).
REQ-035 inst_id=0xFFFFFFFF -> illegal_ex=1, rd_wen_ex=0; beq with imm=-4 -> imm_ex=0xFFFFFFFC.
REQ-036 Decode addi x0,x0,5 -> rd_wen_ex=0; a write with wb_rd=0 leaves x0 reading 0.

Source files
------------

// File: rtl/id_stage.sv
// Instruction decode stage: register file with optional write-back bypass,
// instruction field/immediate decode, load-use hazard detection and the
// ID->EX pipeline register with flush, hold and bubble insertion.
module id_stage #(
    parameter int RF_BYPASS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_id,
    input  logic [31:2] pc_id,
    input  logic        stall,
    input  logic        rst_pipe,
    input  logic        jmp_flush,
    input  logic        wb_wen,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        stall_ld,
    output logic [31:2] pc_ex,
    output logic [6:0]  opcode_ex,
    output logic [2:0]  funct3_ex,
    output logic        funct7b5_ex,
    output logic [4:0]  rs1_ex,
    output logic [4:0]  rs2_ex,
    output logic [4:0]  rd_ex,
    output logic        rd_wen_ex,
    output logic        cmd_ld_ex,
    output logic        illegal_ex,
    output logic [31:0] rs1_data_ex,
    output logic [31:0] rs2_data_ex,
    output logic [31:0] imm_ex
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Entry 0 is never written; reads of x0 are forced to zero below.
    logic [31:0] regs [0:31];

    logic [6:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        legal;
    logic        use_rs1;
    logic        use_rs2;
    logic        rd_wen;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;

    assign opcode = inst_id[6:0];
    assign rs1    = inst_id[19:15];
    assign rs2    = inst_id[24:20];
    assign rd     = inst_id[11:7];
    assign funct3 = inst_id[14:12];

    // Register-file read port with optional same-cycle write-back forwarding.
    function automatic logic [31:0] rf_read(input logic [4:0] idx, input logic [31:0] stored);
        logic [31:0] val;
        if (idx == 5'd0)
            val = 32'd0;
        else if ((RF_BYPASS != 0) && wb_wen && (wb_rd == idx))
            val = wb_data;
        else
            val = stored;
        return val;
    endfunction

    assign rs1_data = rf_read(rs1, regs[rs1]);
    assign rs2_data = rf_read(rs2, regs[rs2]);

    // Register-file write port; runs regardless of stall, flush or reset.
    always_ff @(posedge clk) begin
        if (wb_wen && (wb_rd != 5'd0))
            regs[wb_rd] <= wb_data;
    end

    // Opcode classification, operand usage and destination write enable.
    always_comb begin
        legal   = 1'b0;
        use_rs1 = 1'b1;
        use_rs2 = 1'b0;
        rd_wen  = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL: begin
                legal   = 1'b1;
                use_rs1 = 1'b0;
                rd_wen  = 1'b1;
            end
            OP_JALR, OP_LOAD, OP_IMM: begin
                legal  = 1'b1;
                rd_wen = 1'b1;
            end
            OP_REG: begin
                legal   = 1'b1;
                use_rs2 = 1'b1;
                rd_wen  = 1'b1;
            end
            OP_BRANCH, OP_STORE: begin
                legal   = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_FENCE: begin
                legal   = 1'b1;
                use_rs1 = 1'b0;
            end
            OP_SYSTEM: begin
                legal  = 1'b1;
                rd_wen = (funct3 != 3'd0);
            end
            default: begin
                legal = 1'b0;
            end
        endcase
        // Bits [1:0] are part of the opcode, so a non-11 pattern never matches above.
        if (!legal || (rd == 5'd0))
            rd_wen = 1'b0;
    end

    // Immediate generation, sign-extended from bit 31.
    always_comb begin
        imm = 32'd0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
                imm = {{20{inst_id[31]}}, inst_id[31:20]};
            OP_STORE:
                imm = {{20{inst_id[31]}}, inst_id[31:25], inst_id[11:7]};
            OP_BRANCH:
                imm = {{19{inst_id[31]}}, inst_id[31], inst_id[7], inst_id[30:25], inst_id[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {inst_id[31:12], 12'd0};
            OP_JAL:
                imm = {{11{inst_id[31]}}, inst_id[31], inst_id[19:12], inst_id[20], inst_id[30:21], 1'b0};
            default:
                imm = 32'd0;
        endcase
    end

    // A load in EX whose destination feeds the instruction in ID must wait a cycle.
    assign stall_ld = ~rst & cmd_ld_ex & (rd_ex != 5'd0) &
                      ((use_rs1 & (rs1 == rd_ex)) | (use_rs2 & (rs2 == rd_ex)));

    // ID->EX register: reset/flush bubble, hold on stall, bubble on load-use, else load.
    always_ff @(posedge clk) begin
        if (rst || rst_pipe || jmp_flush || (!stall && stall_ld)) begin
            pc_ex       <= (rst || rst_pipe || jmp_flush) ? 30'd0 : pc_id;
            opcode_ex   <= OP_IMM;
            funct3_ex   <= 3'd0;
            funct7b5_ex <= 1'b0;
            rs1_ex      <= 5'd0;
            rs2_ex      <= 5'd0;
            rd_ex       <= 5'd0;
            rd_wen_ex   <= 1'b0;
            cmd_ld_ex   <= 1'b0;
            illegal_ex  <= 1'b0;
            rs1_data_ex <= 32'd0;
            rs2_data_ex <= 32'd0;
            imm_ex      <= 32'd0;
        end else if (!stall) begin
            pc_ex       <= pc_id;
            opcode_ex   <= opcode;
            funct3_ex   <= funct3;
            funct7b5_ex <= inst_id[30];
            rs1_ex      <= rs1;
            rs2_ex      <= rs2;
            rd_ex       <= rd;
            rd_wen_ex   <= rd_wen;
            cmd_ld_ex   <= (opcode == OP_LOAD);
            illegal_ex  <= ~legal;
            rs1_data_ex <= rs1_data;
            rs2_data_ex <= rs2_data;
            imm_ex      <= imm;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus randomized
// instruction streams compared against a behavioural decode-stage model.
module tb_id_stage;

    localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67,
                           BR = 7'h63, LD = 7'h03, ST = 7'h23, OPI = 7'h13,
                           OPR = 7'h33, FENCE = 7'h0F, SYS = 7'h73;

    logic        clk;
    logic        rst, stall, rst_pipe, jmp_flush, wb_wen;
    logic [31:0] inst_id, wb_data;
    logic [29:0] pc_id;
    logic [4:0]  wb_rd;

    logic        stall_ld, funct7b5_ex, rd_wen_ex, cmd_ld_ex, illegal_ex;
    logic [29:0] pc_ex;
    logic [6:0]  opcode_ex;
    logic [2:0]  funct3_ex;
    logic [4:0]  rs1_ex, rs2_ex, rd_ex;
    logic [31:0] rs1_data_ex, rs2_data_ex, imm_ex;

    logic        nb_stall_ld, nb_funct7b5_ex, nb_rd_wen_ex, nb_cmd_ld_ex, nb_illegal_ex;
    logic [29:0] nb_pc_ex;
    logic [6:0]  nb_opcode_ex;
    logic [2:0]  nb_funct3_ex;
    logic [4:0]  nb_rs1_ex, nb_rs2_ex, nb_rd_ex;
    logic [31:0] nb_rs1_data_ex, nb_rs2_data_ex, nb_imm_ex;

    id_stage #(.RF_BYPASS(1)) u_dut (
        .clk(clk), .rst(rst), .inst_id(inst_id), .pc_id(pc_id), .stall(stall),
        .rst_pipe(rst_pipe), .jmp_flush(jmp_flush), .wb_wen(wb_wen), .wb_rd(wb_rd),
        .wb_data(wb_data), .stall_ld(stall_ld), .pc_ex(pc_ex), .opcode_ex(opcode_ex),
        .funct3_ex(funct3_ex), .funct7b5_ex(funct7b5_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
        .rd_ex(rd_ex), .rd_wen_ex(rd_wen_ex), .cmd_ld_ex(cmd_ld_ex), .illegal_ex(illegal_ex),
        .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex), .imm_ex(imm_ex)
    );

    id_stage #(.RF_BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .inst_id(inst_id), .pc_id(pc_id), .stall(stall),
        .rst_pipe(rst_pipe), .jmp_flush(jmp_flush), .wb_wen(wb_wen), .wb_rd(wb_rd),
        .wb_data(wb_data), .stall_ld(nb_stall_ld), .pc_ex(nb_pc_ex), .opcode_ex(nb_opcode_ex),
        .funct3_ex(nb_funct3_ex), .funct7b5_ex(nb_funct7b5_ex), .rs1_ex(nb_rs1_ex),
        .rs2_ex(nb_rs2_ex), .rd_ex(nb_rd_ex), .rd_wen_ex(nb_rd_wen_ex), .cmd_ld_ex(nb_cmd_ld_ex),
        .illegal_ex(nb_illegal_ex), .rs1_data_ex(nb_rs1_data_ex), .rs2_data_ex(nb_rs2_data_ex),
        .imm_ex(nb_imm_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: architectural registers and expected EX contents.
    logic [31:0] mrf [0:31];
    logic [29:0] e_pc;
    logic [6:0]  e_op;
    logic [2:0]  e_f3;
    logic        e_f7, e_wen, e_ld, e_ill, e_sl, obs_sl;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic [31:0] e_d1, e_d2, e_imm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [6:0] op);
        return op inside {LUI, AUIPC, JAL, JALR, BR, LD, ST, OPI, OPR, FENCE, SYS};
    endfunction

    task automatic set_bubble(input logic [29:0] pc);
        e_pc = pc; e_op = OPI; e_f3 = 3'd0; e_f7 = 1'b0; e_rs1 = 5'd0; e_rs2 = 5'd0;
        e_rd = 5'd0; e_wen = 1'b0; e_ld = 1'b0; e_ill = 1'b0; e_d1 = 32'd0; e_d2 = 32'd0;
        e_imm = 32'd0;
    endtask

    task automatic compare_ex();
        chk("pc_ex", 32'(pc_ex), 32'(e_pc));
        chk("opcode_ex", 32'(opcode_ex), 32'(e_op));
        chk("funct3_ex", 32'(funct3_ex), 32'(e_f3));
        chk("funct7b5_ex", 32'(funct7b5_ex), 32'(e_f7));
        chk("rs1_ex", 32'(rs1_ex), 32'(e_rs1));
        chk("rs2_ex", 32'(rs2_ex), 32'(e_rs2));
        chk("rd_ex", 32'(rd_ex), 32'(e_rd));
        chk("rd_wen_ex", 32'(rd_wen_ex), 32'(e_wen));
        chk("cmd_ld_ex", 32'(cmd_ld_ex), 32'(e_ld));
        chk("illegal_ex", 32'(illegal_ex), 32'(e_ill));
        chk("rs1_data_ex", rs1_data_ex, e_d1);
        chk("rs2_data_ex", rs2_data_ex, e_d2);
        chk("imm_ex", imm_ex, e_imm);
    endtask

    // One clock: drive inputs after the falling edge, check the hazard output,
    // advance the model, then compare the EX register at the next falling edge.
    task automatic step(input logic [31:0] i_inst, input logic [29:0] i_pc,
                        input logic i_s, input logic i_rp, input logic i_jf,
                        input logic i_we, input logic [4:0] i_wr, input logic [31:0] i_wd,
                        input logic i_r, input logic [31:0] i_imm);
        logic [6:0] op;
        logic [4:0] r1, r2, rdf;
        logic       leg, u1, u2;
        rst = i_r; inst_id = i_inst; pc_id = i_pc; stall = i_s; rst_pipe = i_rp;
        jmp_flush = i_jf; wb_wen = i_we; wb_rd = i_wr; wb_data = i_wd;
        #1;
        op = i_inst[6:0]; r1 = i_inst[19:15]; r2 = i_inst[24:20]; rdf = i_inst[11:7];
        leg = (i_inst[1:0] == 2'b11) && is_legal(op);
        u1 = !(op inside {LUI, AUIPC, JAL, FENCE});
        u2 = op inside {BR, ST, OPR};
        e_sl = !i_r && e_ld && (e_rd != 0) && ((u1 && r1 == e_rd) || (u2 && r2 == e_rd));
        obs_sl = stall_ld;
        chk("stall_ld", 32'(stall_ld), 32'(e_sl));
        if (i_r || i_rp || i_jf) set_bubble(30'd0);
        else if (i_s) ;
        else if (e_sl) set_bubble(i_pc);
        else begin
            e_pc = i_pc; e_op = op; e_f3 = i_inst[14:12]; e_f7 = i_inst[30];
            e_rs1 = r1; e_rs2 = r2; e_rd = rdf;
            e_wen = leg && (rdf != 0) &&
                    ((op inside {LUI, AUIPC, JAL, JALR, LD, OPI, OPR}) ||
                     (op == SYS && i_inst[14:12] != 0));
            e_ld = (op == LD); e_ill = !leg; e_imm = i_imm;
            e_d1 = (r1 == 0) ? 32'd0 : (i_we && i_wr == r1) ? i_wd : mrf[r1];
            e_d2 = (r2 == 0) ? 32'd0 : (i_we && i_wr == r2) ? i_wd : mrf[r2];
        end
        if (i_we && i_wr != 0) mrf[i_wr] = i_wd;
        @(negedge clk);
        compare_ex();
    endtask

    function automatic logic [4:0] rreg();
        return ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    endfunction

    // Builds an instruction from a chosen format and immediate value, returning both.
    task automatic gen(output logic [31:0] inst, output logic [31:0] immv);
        int          k, v;
        logic [4:0]  rd, r1, r2;
        logic [2:0]  f3;
        logic [31:0] rnd;
        logic [6:0]  op;
        k = $urandom_range(0, 13);
        rd = rreg(); r1 = rreg(); r2 = rreg(); f3 = 3'($urandom); rnd = $urandom;
        immv = 32'd0;
        case (k)
            0, 1, 2, 3, 4: begin
                op = (k <= 1) ? LD : (k == 2) ? OPI : (k == 3) ? JALR : SYS;
                v = int'($urandom_range(0, 4095)) - 2048; immv = 32'(v);
                inst = {immv[11:0], r1, f3, rd, op};
            end
            5: begin
                v = int'($urandom_range(0, 4095)) - 2048; immv = 32'(v);
                inst = {immv[11:5], r2, r1, f3, immv[4:0], ST};
            end
            6: begin
                v = (int'($urandom_range(0, 4095)) - 2048) * 2; immv = 32'(v);
                inst = {immv[12], immv[10:5], r2, r1, f3, immv[4:1], immv[11], BR};
            end
            7, 8: begin
                immv = {rnd[31:12], 12'd0};
                inst = {immv[31:12], rd, (k == 7) ? LUI : AUIPC};
            end
            9: begin
                v = (int'($urandom_range(0, 1048575)) - 524288) * 2; immv = 32'(v);
                inst = {immv[20], immv[10:1], immv[11], immv[19:12], rd, JAL};
            end
            10, 11: inst = {rnd[31:25], r2, r1, f3, rd, OPR};
            12:     inst = {rnd[31:25], r2, r1, f3, rd, FENCE};
            default: begin
                if ($urandom_range(0, 1) == 1) begin
                    inst = {rnd[31:2], 2'($urandom_range(0, 2))};
                end else begin
                    op = {5'($urandom), 2'b11};
                    while (is_legal(op)) op = {5'($urandom), 2'b11};
                    inst = {rnd[31:7], op};
                end
            end
        endcase
    endtask

    logic [31:0] cur_inst, cur_imm, old9;
    logic [29:0] cur_pc;
    logic        s, rp, jf, r, we;
    logic [4:0]  wr;

    initial begin
        rst = 1'b1; inst_id = 32'h13; pc_id = 30'd0; stall = 1'b0; rst_pipe = 1'b0;
        jmp_flush = 1'b0; wb_wen = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        set_bubble(30'd0); e_sl = 1'b0; obs_sl = 1'b0;
        for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
        @(negedge clk);
        // Fill the register file while reset holds EX in the bubble state.
        for (int i = 1; i < 32; i++)
            step(32'h00000013, 30'h3ABCDEF0 + 30'(i), 1'b1, 1'b0, 1'b0, 1'b1, 5'(i), $urandom,
                 1'b1, 32'd0);
        chk("reset_opcode", 32'(opcode_ex), 32'h13);
        chk("reset_pc", 32'(pc_ex), 32'd0);

        // Write x5 then read it back through add x6,x5,x0.
        step(32'h00000013, 30'd1, 0, 0, 0, 1, 5'd5, 32'h12345678, 0, 32'd0);
        step({7'd0, 5'd0, 5'd5, 3'd0, 5'd6, OPR}, 30'd2, 0, 0, 0, 0, 5'd0, 32'd0, 0, 32'd0);
        chk("add_rs1_data", rs1_data_ex, 32'h12345678);
        chk("add_rd", 32'(rd_ex), 32'd6);
        chk("add_rd_wen", 32'(rd_wen_ex), 32'd1);

        // lw x7,0(x1) then addi x8,x7,1: one bubble, then the addi.
        step({12'd0, 5'd1, 3'b010, 5'd7, LD}, 30'd3, 0, 0, 0, 0, 5'd0, 32'd0, 0, 32'd0);
        step({12'd1, 5'd7, 3'd0, 5'd8, OPI}, 30'd4, 0, 0, 0, 0, 5'd0, 32'd0, 0, 32'd1);
        chk("ld_use_stall", 32'(obs_sl), 32'd1);
        chk("ld_use_bubble_op", 32'(opcode_ex), 32'h13);
        chk("ld_use_bubble_pc", 32'(pc_ex), 32'd4);
        step({12'd1, 5'd7, 3'd0, 5'd8, OPI}, 30'd4, 0, 0, 0, 0, 5'd0, 32'd0, 0, 32'd1);
        chk("ld_use_released", 32'(obs_sl), 32'd0);
        chk("ld_use_rs1", 32'(rs1_ex), 32'd7);
        chk("ld_use_rd", 32'(rd_ex), 32'd8);

        // Same-cycle write-back of x9 while x9 is read as rs2.
        step(32'h00000013, 30'd5, 0, 0, 0, 1, 5'd9, 32'h0BAD0009, 0, 32'd0);
        old9 = mrf[9];
        step({7'd0, 5'd9, 5'd0, 3'd0, 5'd10, OPR}, 30'd6, 0, 0, 0, 1, 5'd9, 32'hA5A5A5A5, 0, 32'd0);
        chk("bypass_rs2", rs2_data_ex, 32'hA5A5A5A5);
        chk("nobypass_rs2", nb_rs2_data_ex, old9);

        // Flush beats stall and a pending load-use hazard.
        step({12'd0, 5'd1, 3'b010, 5'd7, LD}, 30'd7, 0, 0, 0, 0, 5'd0, 32'd0, 0, 32'd0);
        step({12'd1, 5'd7, 3'd0, 5'd8, OPI}, 30'd8, 1, 0, 1, 0, 5'd0, 32'd0, 0, 32'd1);
        chk("flush_op", 32'(opcode_ex), 32'h13);
        chk("flush_rd_wen", 32'(rd_wen_ex), 32'd0);
        chk("flush_pc", 32'(pc_ex), 32'd0);

        // All-ones word is illegal; beq x1,x2,-4 decodes imm -4.
        step(32'hFFFFFFFF, 30'd9, 0, 0, 0, 0, 5'd0, 32'd0, 0, 32'd0);
        chk("illegal_flag", 32'(illegal_ex), 32'd1);
        chk("illegal_rd_wen", 32'(rd_wen_ex), 32'd0);
        step(32'hFE208EE3, 30'd10, 0, 0, 0, 0, 5'd0, 32'd0, 0, 32'hFFFFFFFC);
        chk("beq_imm", imm_ex, 32'hFFFFFFFC);

        // addi x0,x0,5 never writes; a write to x0 leaves it reading zero.
        step(32'h00500013, 30'd11, 0, 0, 0, 1, 5'd0, 32'hDEADBEEF, 0, 32'd5);
        chk("x0_rd_wen", 32'(rd_wen_ex), 32'd0);
        chk("x0_bypass", rs1_data_ex, 32'd0);
        step({7'd0, 5'd0, 5'd0, 3'd0, 5'd11, OPR}, 30'd12, 0, 0, 0, 0, 5'd0, 32'd0, 0, 32'd0);
        chk("x0_read", rs1_data_ex, 32'd0);

        // Randomized stream; fetch holds the instruction while stalled.
        gen(cur_inst, cur_imm);
        cur_pc = 30'($urandom);
        for (int n = 0; n < 800; n++) begin
            s  = ($urandom_range(0, 99) < 15);
            jf = ($urandom_range(0, 99) < 5);
            rp = ($urandom_range(0, 99) < 3);
            r  = ($urandom_range(0, 99) < 2);
            we = ($urandom_range(0, 99) < 60);
            wr = rreg();
            step(cur_inst, cur_pc, s, rp, jf, we, wr, $urandom, r, cur_imm);
            if (!(s || e_sl)) begin
                gen(cur_inst, cur_imm);
                cur_pc = 30'($urandom);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
